// File: rtl/cache_pkg.sv
// Definitions shared by the instruction cache and the bus arbiter.
package cache_pkg;
  localparam int LINE_BYTES = 64;
  localparam int WORD_BITS  = 64;
  localparam int LINE_BITS  = 512;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESPOND
  } fill_state_e;

  function automatic logic [63:0] line_addr(input logic [63:0] addr);
    return addr & ~64'(LINE_BYTES - 1);
  endfunction
endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits, tags and line data with one read
// port, one write port and a single-cycle clear of every valid bit.
module icache_array
  import cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 64 - 6 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output line_t            rd_line_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  line_t            wr_line_i,
  input  logic             clear_all_i
);
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  line_t            data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset: they are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];
endmodule

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache front end: hit lookup plus the line-fill
// FSM talking to the arbiter's irequest/ireqack/idone handshake.
module icache_fill
  import cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_BYTES = cache_pkg::LINE_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [63:0]          fetch_addr,
  output logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [63:0]          fetch_data,
  input  logic                 flush,
  output logic                 irequest,
  input  logic                 ireqack,
  output logic [63:0]          iaddr,
  input  logic [LINE_BITS-1:0] idata,
  input  logic                 idone
);
  localparam int OFF_LSB = 3;
  localparam int IDX_LSB = $clog2(LINE_BYTES);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = 64 - TAG_LSB;

  fill_state_e         state_q, state_d;
  logic [63:OFF_LSB]   addr_q, addr_d;
  logic                booted_q;
  logic                fetch_valid_q, fetch_valid_d;
  logic [63:0]         fetch_data_q, fetch_data_d;
  logic                irequest_q, irequest_d;
  logic [63:0]         iaddr_q, iaddr_d;
  logic                flush_pend_q, flush_pend_d;
  logic                clear_all, wr_en;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  line_t               rd_line;

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [IDX_LSB-4:0]     off;
  logic                   unused_addr_bits;

  assign idx = addr_q[TAG_LSB-1:IDX_LSB];
  assign tag = addr_q[63:TAG_LSB];
  assign off = addr_q[IDX_LSB-1:OFF_LSB];
  assign unused_addr_bits = ^fetch_addr[OFF_LSB-1:0];

  icache_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk         (clk),
    .rst_n       (reset),
    .rd_idx_i    (idx),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_en_i     (wr_en),
    .wr_idx_i    (idx),
    .wr_tag_i    (tag),
    .wr_line_i   (idata),
    .clear_all_i (clear_all)
  );

  // A deferred flush blocks acceptance for the one IDLE cycle in which it clears.
  assign fetch_ready = booted_q && (state_q == IDLE) && !flush_pend_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    irequest_d    = irequest_q;
    iaddr_d       = iaddr_q;
    flush_pend_d  = flush_pend_q;
    clear_all     = 1'b0;
    wr_en         = 1'b0;
    if (flush && state_q != IDLE) flush_pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        clear_all    = flush || flush_pend_q;
        if (fetch_req && fetch_ready) begin
          addr_d  = fetch_addr[63:OFF_LSB];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (rd_valid && rd_tag == tag) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = rd_line[{off, 6'b0} +: WORD_BITS];
          state_d       = IDLE;
        end else begin
          irequest_d = 1'b1;
          iaddr_d    = line_addr({addr_q, 3'b000});
          state_d    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (ireqack) begin
          irequest_d = 1'b0;
          state_d    = MISS_WAIT;
          // Ack and completion together: the fill finishes in this same cycle.
          if (idone) begin
            wr_en         = 1'b1;
            fetch_valid_d = 1'b1;
            fetch_data_d  = idata[{off, 6'b0} +: WORD_BITS];
            state_d       = RESPOND;
          end
        end
      end
      MISS_WAIT: begin
        if (idone) begin
          wr_en         = 1'b1;
          fetch_valid_d = 1'b1;
          fetch_data_d  = idata[{off, 6'b0} +: WORD_BITS];
          state_d       = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      booted_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      irequest_q    <= 1'b0;
      iaddr_q       <= '0;
      flush_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      booted_q      <= 1'b1;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      irequest_q    <= irequest_d;
      iaddr_q       <= iaddr_d;
      flush_pend_q  <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign irequest    = irequest_q;
  assign iaddr       = iaddr_q;
endmodule

// File: doc/icache_fill.md
Name: icache_fill

Overview:
- Direct-mapped instruction cache between the fetch stage and the bus arbiter's instruction port.
- Serves 64-bit aligned fetch words on a hit.
- On a miss, requests a full 64-byte line through the arbiter's `irequest`/`ireqack`/`idone` handshake, installs the line, then answers the pending fetch.

Parameters:
- SETS, 64, number of lines; power of two, 2..1024.
- LINE_BYTES, 64, line size; fixed at 64 to match the arbiter's 512-bit transfer.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; qualified by fetch_ready.
- fetch_addr  in  64  fetch byte address; bits [2:0] ignored.
- fetch_ready  out  1  cache can accept a fetch this cycle.
- fetch_valid  out  1  one-cycle pulse; fetch_data valid.
- fetch_data  out  64  instruction word at fetch_addr & ~7.
- flush  in  1  invalidate all lines.
- irequest  out  1  line request to arbiter.
- ireqack  in  1  arbiter accepted request (one-cycle pulse).
- iaddr  out  64  line address to arbiter; bits [5:0] = 0.
- idata  in  512  returned line; word k = idata[k*64+:64] = bytes 8k..8k+7.
- idone  in  1  one-cycle pulse; idata valid this cycle.

Behaviour:
- Address split:
  - off = addr[5:3]
  - idx = addr[6+log2(SETS)-1:6]
  - tag = addr[63:6+log2(SETS)]
- Per-set storage: valid bit, tag, 512-bit data.
- Reset (reset=0, async):
  - state=IDLE; all valid bits=0.
  - fetch_valid=0, fetch_data=0, irequest=0, iaddr=0, flush_pend=0.
  - fetch_ready=0 while reset is asserted; fetch_ready=1 from the first posedge after deassertion.
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESPOND.
- IDLE:
  - fetch_ready=1.
  - Accept (fetch_req && fetch_ready): latch fetch_addr, go to LOOKUP.
- LOOKUP:
  - fetch_ready=0.
  - Hit (valid[idx] && tag match): fetch_valid=1, fetch_data=line[off], go to IDLE.
    - Hit latency is 2 cycles from accept edge to fetch_valid.
    - One fetch is accepted per 2 cycles.
  - Miss: irequest=1, iaddr={addr[63:6],6'b0}, go to MISS_REQ.
- MISS_REQ:
  - Hold irequest and iaddr stable until ireqack=1.
  - Then irequest=0, go to MISS_WAIT.
- MISS_WAIT:
  - On idone=1: write idata to set idx, set valid[idx]=1, store tag.
  - Capture fetch_data=idata[off*64+:64] and go to RESPOND.
- RESPOND:
  - fetch_valid=1 for exactly one cycle, then IDLE.
- Timing rules:
  - fetch_valid is high only in the cycle following LOOKUP-hit or in RESPOND; never two consecutive cycles.
  - iaddr holds its value after request completion; only irequest is meaningful.
- ireqack and idone in the same cycle while in MISS_REQ:
  - Treat as ack followed immediately by completion: install the line, go to RESPOND.
- idone or ireqack in IDLE/LOOKUP/RESPOND: ignored. This covers stale completions after reset.
- Flush:
  - In IDLE, flush clears all valid bits at the next edge.
  - A fetch accepted in the same cycle proceeds to LOOKUP and sees the cleared array (flush wins).
  - In any other state: set flush_pend.
  - A fill in progress still installs its line and still responds.
  - The clear executes on entry to IDLE; fetch_ready stays 0 for that one cycle.
- Reset mid-miss:
  - Abandon the miss: irequest=0 immediately (async); no fetch_valid.
- Array:
  - Flop-based or synchronous-read; read in LOOKUP uses the latched address.
  - A write in MISS_WAIT must be visible to a LOOKUP 2 cycles later.

Decomposition:
- Shared package (cache_pkg), with the arbiter:
  - LINE_BYTES, WORD_BITS=64, LINE_BITS=512.
  - Typedef line_t (logic[511:0]).
  - Function line_addr(addr) returning {addr[63:6],6'b0}.
- One sub-module, icache_array: valid/tag/data storage with read port, write port and clear_all. The FSM stays in icache_fill.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch 0x1008; arbiter acks after 3 cycles; idone after 10 cycles with word k = 0x1000_0000+k.
  - Required: iaddr=0x1000; fetch_data=0x1000_0001.
- Hit after fill:
  - Stimulus: fetch 0x1038.
  - Required: fetch_valid exactly 2 cycles after accept, data 0x1000_0007, irequest stays 0.
- Conflict miss (SETS=64):
  - Stimulus: fetch 0x2008 (same idx 0), then 0x1008.
  - Required: two separate line requests, iaddr=0x2000 then iaddr=0x1000.
- Flush:
  - Stimulus: fill 0x1000, pulse flush in IDLE, fetch 0x1000.
  - Required: miss with irequest=1, iaddr=0x1000.
  - Stimulus: flush during MISS_WAIT.
  - Required: pending fetch still answered; the next fetch to that line misses.
- Simultaneous handshake:
  - Stimulus: ireqack and idone in the same cycle.
  - Required: line installed, fetch_valid one cycle later.
  - Stimulus: spurious idone in IDLE.
  - Required: no fetch_valid, no array change.
- Reset mid-miss:
  - Stimulus: assert reset while in MISS_REQ.
  - Required: irequest=0 with no clock edge; after release, fetch_ready=1 at the first posedge; a late idone is ignored; the next fetch misses.
